branch_predict_unit: RTL and testbench

Parametrised successor to the EX-stage branch condition unit. It resolves conditional branches from ALU flags and adds a direct-mapped table of saturating taken/not-taken counters. The table is read combinationally in IF and trained when a branch resolves in EX. It flags mispredictions for pipeline redirect/flush and keeps saturating branch and mispredict statistics.

---
 rtl/branch_predict_unit.sv | 122 ++++++++++++
 tb/tb_branch_predict_unit.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// branch_predict_unit
// Resolves conditional branches from ALU subtraction flags and keeps a
// direct-mapped table of saturating taken/not-taken counters. The table is
// read combinationally in IF and trained when a legal branch resolves in EX.
// Mispredictions are flagged for redirect/flush, and saturating branch and
// mispredict statistics are kept.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   lookup_pc         IF-stage PC; predict_taken = MSB of indexed counter
//   resolve_valid     EX holds a conditional branch this cycle
//   resolve_pc        PC of the resolving branch (selects entry to train)
//   func3             branch funct3 (BEQ/BNE/BLT/BGE/BLTU/BGEU)
//   cf, zf, sf, vf    flags of rs1-rs2; cf=1 means no borrow
//   predicted_taken   prediction carried down the pipe with this branch
//   actual_taken      resolved outcome (combinational)
//   mispredict        redirect request (combinational)
//   illegal_branch    resolve_valid with reserved funct3 010/011
//   branch_count      saturating count of legal resolved branches
//   mispredict_count  saturating count of mispredicts
module branch_predict_unit #(
  parameter int unsigned PC_WIDTH   = 32,
  parameter int unsigned INDEX_BITS = 4,
  parameter int unsigned CNT_BITS   = 2,
  parameter int unsigned STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PC_WIDTH-1:0]   lookup_pc,
  output logic                  predict_taken,
  input  logic                  resolve_valid,
  input  logic [PC_WIDTH-1:0]   resolve_pc,
  input  logic [2:0]            func3,
  input  logic                  cf,
  input  logic                  zf,
  input  logic                  sf,
  input  logic                  vf,
  input  logic                  predicted_taken,
  output logic                  actual_taken,
  output logic                  mispredict,
  output logic                  illegal_branch,
  output logic [STAT_WIDTH-1:0] branch_count,
  output logic [STAT_WIDTH-1:0] mispredict_count
);

  localparam int unsigned Entries = 2 ** INDEX_BITS;
  // Weakly-not-taken: MSB clear, all lower bits set.
  localparam logic [CNT_BITS-1:0]   CntInit = CNT_BITS'((1 << (CNT_BITS - 1)) - 1);
  localparam logic [CNT_BITS-1:0]   CntMax  = '1;
  localparam logic [STAT_WIDTH-1:0] StatMax = '1;

  logic [CNT_BITS-1:0]   table_q [Entries];
  logic [INDEX_BITS-1:0] lookup_idx;
  logic [INDEX_BITS-1:0] resolve_idx;
  logic [CNT_BITS-1:0]   cnt_cur;
  logic [CNT_BITS-1:0]   cnt_d;
  logic                  update_en;
  logic [STAT_WIDTH-1:0] branch_q, branch_d;
  logic [STAT_WIDTH-1:0] mispred_q, mispred_d;
  logic                  unused_pc_bits;

  // Word-aligned PCs: bits [1:0] never select an entry; upper bits alias.
  assign lookup_idx  = lookup_pc[INDEX_BITS+1:2];
  assign resolve_idx = resolve_pc[INDEX_BITS+1:2];
  assign unused_pc_bits = ^{lookup_pc[PC_WIDTH-1:INDEX_BITS+2], lookup_pc[1:0],
                            resolve_pc[PC_WIDTH-1:INDEX_BITS+2], resolve_pc[1:0]};

  // Reads current contents, so a same-cycle update is not bypassed.
  assign predict_taken = table_q[lookup_idx][CNT_BITS-1];

  always_comb begin
    actual_taken   = 1'b0;
    illegal_branch = 1'b0;
    if (resolve_valid) begin
      case (func3)
        3'b000:  actual_taken = zf;
        3'b001:  actual_taken = ~zf;
        3'b100:  actual_taken = sf ^ vf;
        3'b101:  actual_taken = ~(sf ^ vf);
        3'b110:  actual_taken = ~cf;
        3'b111:  actual_taken = cf;
        default: illegal_branch = 1'b1;
      endcase
    end
  end

  assign update_en  = resolve_valid & ~illegal_branch;
  assign mispredict = update_en & (actual_taken ^ predicted_taken);

  always_comb begin
    cnt_cur = table_q[resolve_idx];
    cnt_d   = cnt_cur;
    if (actual_taken) begin
      if (cnt_cur != CntMax) cnt_d = cnt_cur + 1'b1;
    end else if (cnt_cur != '0) begin
      cnt_d = cnt_cur - 1'b1;
    end
  end

  always_comb begin
    branch_d  = branch_q;
    mispred_d = mispred_q;
    if (update_en && branch_q != StatMax) branch_d = branch_q + 1'b1;
    if (mispredict && mispred_q != StatMax) mispred_d = mispred_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(Entries); i++) table_q[i] <= CntInit;
      branch_q  <= '0;
      mispred_q <= '0;
    end else begin
      if (update_en) table_q[resolve_idx] <= cnt_d;
      branch_q  <= branch_d;
      mispred_q <= mispred_d;
    end
  end

  assign branch_count     = branch_q;
  assign mispredict_count = mispred_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lookup_pc;
  logic        resolve_valid;
  logic [31:0] resolve_pc;
  logic [2:0]  func3;
  logic        cf, zf, sf, vf;
  logic        predicted_taken;

  logic        predict_taken, actual_taken, mispredict, illegal_branch;
  logic [15:0] branch_count, mispredict_count;
  logic        s_predict_taken, s_actual_taken, s_mispredict, s_illegal_branch;
  logic [1:0]  s_branch_count, s_mispredict_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predict_unit dut (
    .clk              (clk),
    .rst              (rst),
    .lookup_pc        (lookup_pc),
    .predict_taken    (predict_taken),
    .resolve_valid    (resolve_valid),
    .resolve_pc       (resolve_pc),
    .func3            (func3),
    .cf               (cf),
    .zf               (zf),
    .sf               (sf),
    .vf               (vf),
    .predicted_taken  (predicted_taken),
    .actual_taken     (actual_taken),
    .mispredict       (mispredict),
    .illegal_branch   (illegal_branch),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  // Narrow statistics instance for saturation checks; shares all inputs.
  branch_predict_unit #(.STAT_WIDTH(2)) dut_s (
    .clk              (clk),
    .rst              (rst),
    .lookup_pc        (lookup_pc),
    .predict_taken    (s_predict_taken),
    .resolve_valid    (resolve_valid),
    .resolve_pc       (resolve_pc),
    .func3            (func3),
    .cf               (cf),
    .zf               (zf),
    .sf               (sf),
    .vf               (vf),
    .predicted_taken  (predicted_taken),
    .actual_taken     (s_actual_taken),
    .mispredict       (s_mispredict),
    .illegal_branch   (s_illegal_branch),
    .branch_count     (s_branch_count),
    .mispredict_count (s_mispredict_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic [2:0] f3, input logic c,
                         input logic z, input logic s, input logic v, input logic pt);
    resolve_valid   = 1'b1;
    resolve_pc      = pc;
    func3           = f3;
    cf              = c;
    zf              = z;
    sf              = s;
    vf              = v;
    predicted_taken = pt;
  endtask

  task automatic idle();
    resolve_valid   = 1'b0;
    func3           = 3'b000;
    cf              = 1'b0;
    zf              = 1'b0;
    sf              = 1'b0;
    vf              = 1'b0;
    predicted_taken = 1'b0;
  endtask

  // Combinational outcome check only; resolve_valid drops before the next edge.
  task automatic sweep(input string tag, input logic [2:0] f3, input logic c, input logic z,
                       input logic s, input logic v, input logic exp_taken);
    tick();
    resolve(32'h80, f3, c, z, s, v, 1'b0);
    #1;
    check(tag, {31'd0, actual_taken}, {31'd0, exp_taken});
    check({tag, "_mp"}, {31'd0, mispredict}, {31'd0, exp_taken});
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    lookup_pc  = 32'h40;
    resolve_pc = 32'h0;
    idle();
    tick();
    tick();
    rst = 1'b0;
    #1;
    // Reset state
    check("rst_predict", {31'd0, predict_taken}, 32'd0);
    check("rst_branch_count", {16'd0, branch_count}, 32'd0);
    check("rst_mispredict_count", {16'd0, mispredict_count}, 32'd0);
    check("rst_actual", {31'd0, actual_taken}, 32'd0);
    check("rst_mispredict", {31'd0, mispredict}, 32'd0);
    check("rst_illegal", {31'd0, illegal_branch}, 32'd0);

    // BEQ taken at 0x40 predicted not-taken, twice: 01 -> 10 -> 11
    resolve(32'h40, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("beq1_actual", {31'd0, actual_taken}, 32'd1);
    check("beq1_mispredict", {31'd0, mispredict}, 32'd1);
    check("beq1_predict_old", {31'd0, predict_taken}, 32'd0);
    tick();
    check("beq2_predict", {31'd0, predict_taken}, 32'd1);
    check("beq2_mispredict", {31'd0, mispredict}, 32'd1);
    tick();
    idle();
    #1;
    check("beq_mispredict_count", {16'd0, mispredict_count}, 32'd2);
    check("beq_branch_count", {16'd0, branch_count}, 32'd2);
    check("beq_predict_after", {31'd0, predict_taken}, 32'd1);

    // Saturate high: 5 more taken (predicted taken) keep entry at 11
    resolve(32'h40, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    // One not-taken: 11 -> 10, still predicts taken
    resolve(32'h40, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    #1;
    check("sat_hi_predict", {31'd0, predict_taken}, 32'd1);
    // Second not-taken: 10 -> 01
    resolve(32'h40, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    #1;
    check("sat_hi_second_nt", {31'd0, predict_taken}, 32'd0);
    check("sat_hi_branch_count", {16'd0, branch_count}, 32'd9);
    check("sat_hi_mispredict_count", {16'd0, mispredict_count}, 32'd4);

    // Saturate low at 0x48: 3 not-taken 01 -> 00 -> 00 -> 00
    lookup_pc = 32'h48;
    resolve(32'h48, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    idle();
    #1;
    check("sat_lo_predict", {31'd0, predict_taken}, 32'd0);
    resolve(32'h48, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    #1;
    check("sat_lo_one_taken", {31'd0, predict_taken}, 32'd0);
    resolve(32'h48, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    #1;
    check("sat_lo_two_taken", {31'd0, predict_taken}, 32'd1);
    check("sat_lo_branch_count", {16'd0, branch_count}, 32'd14);
    check("sat_lo_mispredict_count", {16'd0, mispredict_count}, 32'd6);

    // Flag decode sweep (no clock edge sees resolve_valid)
    sweep("blt_sf1_vf0", 3'b100, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    sweep("blt_sf1_vf1", 3'b100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    sweep("bge_sf1_vf1", 3'b101, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    sweep("bltu_cf1", 3'b110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    sweep("bltu_cf0", 3'b110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    sweep("bgeu_cf1", 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    sweep("bne_zf1", 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    func3 = 3'b111;
    cf    = 1'b1;
    #1;
    check("novalid_actual", {31'd0, actual_taken}, 32'd0);
    idle();

    // Illegal func3=010 at 0x40 (entry 01), predicted taken
    tick();
    lookup_pc = 32'h40;
    resolve(32'h40, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    check("illegal_flag", {31'd0, illegal_branch}, 32'd1);
    check("illegal_mispredict", {31'd0, mispredict}, 32'd0);
    check("illegal_actual", {31'd0, actual_taken}, 32'd0);
    tick();
    idle();
    #1;
    check("illegal_branch_count", {16'd0, branch_count}, 32'd14);
    check("illegal_mispredict_count", {16'd0, mispredict_count}, 32'd6);
    // Entry must still be 01: one taken reaches 10
    resolve(32'h40, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    tick();
    idle();
    #1;
    check("illegal_entry_intact", {31'd0, predict_taken}, 32'd1);

    // Same-cycle lookup/update at 0x44 (entry 01, taken)
    lookup_pc = 32'h44;
    resolve(32'h44, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("bypass_same_cycle", {31'd0, predict_taken}, 32'd0);
    tick();
    idle();
    #1;
    check("bypass_next_cycle", {31'd0, predict_taken}, 32'd1);
    check("bypass_branch_count", {16'd0, branch_count}, 32'd16);
    check("bypass_mispredict_count", {16'd0, mispredict_count}, 32'd7);

    // Reset with a simultaneous resolve; lookup reads pre-reset contents
    rst = 1'b1;
    resolve(32'h44, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    check("rst_cycle_predict_old", {31'd0, predict_taken}, 32'd1);
    tick();
    tick();
    rst = 1'b0;
    idle();
    #1;
    check("rst_res_branch_count", {16'd0, branch_count}, 32'd0);
    check("rst_res_mispredict_count", {16'd0, mispredict_count}, 32'd0);
    check("rst_res_entry", {31'd0, predict_taken}, 32'd0);
    check("rst_s_mispredict_count", {30'd0, s_mispredict_count}, 32'd0);

    // Five mispredicts: wide counters reach 5, STAT_WIDTH=2 saturates at 3
    resolve(32'h4c, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    idle();
    #1;
    check("stat_wide_mispredict", {16'd0, mispredict_count}, 32'd5);
    check("stat_wide_branch", {16'd0, branch_count}, 32'd5);
    check("stat_sat_mispredict", {30'd0, s_mispredict_count}, 32'd3);
    check("stat_sat_branch", {30'd0, s_branch_count}, 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
